// File: rtl/spram_arbiter_if.sv
// rtl/spram_arbiter_if.sv - requester-side bus for the shared SPRAM bank (fetch port A, load/store port B)
interface spram_arbiter_if;
    logic        a_req;
    logic [13:0] a_addr;
    logic        a_gnt;
    logic        a_rvalid;
    logic [31:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [3:0]  b_be;
    logic [13:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [31:0] b_rdata;

    modport master (
        output a_req, a_addr,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_be, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_addr,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_be, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - round-robin fetch/LSU arbiter for a 32-bit SPRAM bank with standby power management
module spram_arbiter #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    spram_arbiter_if.slave   bus,
    output logic [13:0]      ram_addr,
    output logic [31:0]      ram_datain,
    output logic [7:0]       ram_maskwren,
    output logic             ram_wren,
    output logic             ram_cs,
    output logic             ram_standby,
    input  logic [31:0]      ram_dataout,
    output logic [1:0]       pm_state
);

    // A zero-width counter is not legal, so the disabled case keeps one bit
    localparam int          IW        = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_SAT  = '1;
    localparam logic [3:0]  WAKE_LAST = 4'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_STANDBY = 2'd1,
        ST_WAKE    = 2'd2
    } pm_state_t;

    pm_state_t     state, state_next;
    logic [IW-1:0] idle_cnt, idle_next;
    logic [3:0]    wake_cnt, wake_next;
    logic          last_b;      // 1 = port B was granted most recently
    logic          a_rvalid_q, b_rvalid_q;
    logic          grant_a, grant_b, serve, any_req;

    // Grant decode: only in ACTIVE, tie goes to the port that did not win last;
    // reset gating keeps grants and RAM strobes low while rst_n is held
    always_comb begin
        any_req = bus.a_req | bus.b_req;
        serve   = rst_n && (state == ST_ACTIVE);
        grant_a = serve && bus.a_req && (!bus.b_req || last_b);
        grant_b = serve && bus.b_req && (!bus.a_req || !last_b);
    end

    // Power-management next state: idle countdown to STANDBY, wake on demand
    always_comb begin
        state_next = state;
        idle_next  = idle_cnt;
        wake_next  = wake_cnt;
        case (state)
            ST_ACTIVE: begin
                if (any_req) begin
                    idle_next = '0;
                end else if ((IDLE_CYCLES > 0) && (idle_cnt == IDLE_LAST)) begin
                    state_next = ST_STANDBY;
                    idle_next  = '0;
                end else if (idle_cnt != IDLE_SAT) begin
                    idle_next = idle_cnt + IW'(1);
                end
            end
            ST_STANDBY: begin
                if (any_req) begin
                    state_next = ST_WAKE;
                    wake_next  = 4'd0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_next = ST_ACTIVE;
                end else begin
                    wake_next = wake_cnt + 4'd1;
                end
            end
            default: state_next = ST_ACTIVE;
        endcase
    end

    // State, counters, round-robin pointer and read-valid pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACTIVE;
            idle_cnt   <= '0;
            wake_cnt   <= 4'd0;
            last_b     <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state      <= state_next;
            idle_cnt   <= idle_next;
            wake_cnt   <= wake_next;
            if (grant_b) begin
                last_b <= 1'b1;
            end else if (grant_a) begin
                last_b <= 1'b0;
            end
            a_rvalid_q <= grant_a;
            b_rvalid_q <= grant_b && !bus.b_we;
        end
    end

    // RAM control: winner's address, write data and byte-to-nibble mask expansion
    always_comb begin
        ram_cs       = grant_a | grant_b;
        ram_wren     = grant_b & bus.b_we;
        ram_addr     = grant_b ? bus.b_addr : bus.a_addr;
        ram_datain   = bus.b_wdata;
        ram_maskwren = 8'h00;
        if (ram_wren) begin
            for (int i = 0; i < 4; i++) begin
                ram_maskwren[2*i +: 2] = {2{bus.b_be[i]}};
            end
        end
    end

    assign ram_standby  = (state == ST_STANDBY);
    assign pm_state     = state;
    assign bus.a_gnt    = grant_a;
    assign bus.b_gnt    = grant_b;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = ram_dataout;
    assign bus.b_rdata  = ram_dataout;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - directed scoreboard bench for spram_arbiter
module tb_spram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spram_arbiter_if bus ();
    spram_arbiter_if bus0 ();

    logic [13:0] ram_addr, ram_addr0;
    logic [31:0] ram_datain, ram_datain0;
    logic [7:0]  ram_maskwren, ram_maskwren0;
    logic        ram_wren, ram_cs, ram_standby;
    logic        ram_wren0, ram_cs0, ram_standby0;
    logic [31:0] ram_dataout = 32'h0;
    logic [31:0] ram_dataout0 = 32'h0;
    logic [1:0]  pm_state, pm_state0;

    spram_arbiter #(.IDLE_CYCLES(16), .WAKE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_maskwren(ram_maskwren),
        .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_standby(ram_standby),
        .ram_dataout(ram_dataout), .pm_state(pm_state)
    );

    spram_arbiter #(.IDLE_CYCLES(0), .WAKE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .ram_addr(ram_addr0), .ram_datain(ram_datain0), .ram_maskwren(ram_maskwren0),
        .ram_wren(ram_wren0), .ram_cs(ram_cs0), .ram_standby(ram_standby0),
        .ram_dataout(ram_dataout0), .pm_state(pm_state0)
    );

    // SPRAM pair model: nibble-masked write, registered read, frozen in standby
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (ram_cs && !ram_standby) begin
            if (ram_wren) begin
                for (int i = 0; i < 8; i++) begin
                    if (ram_maskwren[i]) mem[ram_addr][4*i +: 4] <= ram_datain[4*i +: 4];
                end
            end else begin
                ram_dataout <= mem[ram_addr];
            end
        end
    end

    // IDLE_CYCLES = 0 instance must never leave ACTIVE
    int cyc0 = 0;
    int bad0 = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            cyc0 = cyc0 + 1;
            if (pm_state0 != 2'd0 || ram_standby0) bad0 = bad0 + 1;
        end
    end

    int total = 0;
    int passed = 0;
    int failed = 0;
    logic [31:0] shadow [0:16383];
    logic [32:0] sb [$];

    logic [13:0] s_addr;
    logic [31:0] s_datain;
    logic [7:0]  s_mask;
    logic        s_wren, s_cs, s_standby, s_brv;
    logic [1:0]  s_pm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, retire read results, check grants, queue expectations
    task automatic step(input logic ea, input logic eb, input string tag);
        logic [32:0] e;
        @(negedge clk);
        if (bus.a_rvalid) begin
            e = (sb.size() != 0) ? sb.pop_front() : 33'h1_FFFF_FFFF;
            chk({tag, " a_rv_port"}, 32'(e[32]), 32'd0);
            chk({tag, " a_rdata"}, bus.a_rdata, e[31:0]);
        end
        if (bus.b_rvalid) begin
            e = (sb.size() != 0) ? sb.pop_front() : 33'h0_FFFF_FFFF;
            chk({tag, " b_rv_port"}, 32'(e[32]), 32'd1);
            chk({tag, " b_rdata"}, bus.b_rdata, e[31:0]);
        end
        chk({tag, " pending_reads"}, 32'(sb.size()), 32'd0);
        sb.delete();
        chk({tag, " a_gnt"}, 32'(bus.a_gnt), 32'(ea));
        chk({tag, " b_gnt"}, 32'(bus.b_gnt), 32'(eb));
        s_addr = ram_addr; s_datain = ram_datain; s_mask = ram_maskwren;
        s_wren = ram_wren; s_cs = ram_cs; s_standby = ram_standby; s_pm = pm_state;
        s_brv = bus.b_rvalid;
        if (ea) sb.push_back({1'b0, shadow[bus.a_addr]});
        if (eb && !bus.b_we) sb.push_back({1'b1, shadow[bus.b_addr]});
        if (eb && bus.b_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.b_be[i]) shadow[bus.b_addr][8*i +: 8] = bus.b_wdata[8*i +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pm_bad;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 32'h0;
            shadow[i] = 32'h0;
        end
        mem[14'h0123] = 32'hDEADBEEF;
        shadow[14'h0123] = 32'hDEADBEEF;
        bus.a_req = 0; bus.a_addr = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_be = '0; bus.b_addr = '0; bus.b_wdata = '0;
        bus0.a_req = 0; bus0.a_addr = '0;
        bus0.b_req = 0; bus0.b_we = 0; bus0.b_be = '0; bus0.b_addr = '0; bus0.b_wdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst outputs", {22'd0, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid,
                            ram_cs, ram_wren, ram_standby, pm_state, 1'b0},
            32'd0);
        chk("rst maskwren", 32'(ram_maskwren), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: A and B reading, alternating grants starting with A
        bus.a_req = 1; bus.a_addr = 14'h0123;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 14'h0010;
        step(1, 0, "rr1");
        chk("rr1 ram_addr", 32'(s_addr), 32'h0123);
        step(0, 1, "rr2");
        chk("rr2 ram_addr", 32'(s_addr), 32'h0010);
        step(1, 0, "rr3");
        step(0, 1, "rr4");
        bus.a_req = 0; bus.b_req = 0;
        step(0, 0, "rr drain");

        // Single fetch read
        bus.a_req = 1; bus.a_addr = 14'h0123;
        step(1, 0, "rd");
        chk("rd cs", 32'(s_cs), 32'd1);
        chk("rd wren", 32'(s_wren), 32'd0);
        bus.a_req = 0;
        step(0, 0, "rd drain");

        // Byte write with b_be = 0101
        bus.b_req = 1; bus.b_we = 1; bus.b_be = 4'b0101; bus.b_addr = 14'h0010;
        bus.b_wdata = 32'hAABBCCDD;
        step(0, 1, "bw");
        chk("bw maskwren", 32'(s_mask), 32'h33);
        chk("bw wren", 32'(s_wren), 32'd1);
        chk("bw datain", s_datain, 32'hAABBCCDD);
        bus.b_req = 0; bus.b_we = 0;
        step(0, 0, "bw gap");
        chk("bw no rvalid", 32'(s_brv), 32'd0);

        // Write with no byte enables leaves memory untouched
        bus.b_req = 1; bus.b_we = 1; bus.b_be = 4'b0000; bus.b_wdata = 32'hFFFFFFFF;
        step(0, 1, "bw0");
        chk("bw0 wren", 32'(s_wren), 32'd1);
        chk("bw0 maskwren", 32'(s_mask), 32'd0);
        bus.b_we = 0;
        step(0, 1, "readback");
        bus.b_req = 0;
        step(0, 0, "readback drain");
        chk("readback shadow", shadow[14'h0010], 32'h00BB00DD);

        // Idle 16 cycles (drain above counts as the first) then STANDBY
        pm_bad = 0;
        if (s_pm != 2'd0) pm_bad++;
        for (int i = 0; i < 15; i++) begin
            step(0, 0, "idle");
            if (s_pm != 2'd0 || s_standby) pm_bad++;
        end
        chk("idle still active", 32'(pm_bad), 32'd0);
        step(0, 0, "sleep");
        chk("sleep pm_state", 32'(s_pm), 32'd1);
        chk("sleep standby", 32'(s_standby), 32'd1);
        chk("sleep cs", 32'(s_cs), 32'd0);

        // Wake on fetch request
        bus.a_req = 1; bus.a_addr = 14'h0123;
        step(0, 0, "standby req");
        chk("standby req pm", 32'(s_pm), 32'd1);
        step(0, 0, "wake");
        chk("wake pm", 32'(s_pm), 32'd2);
        chk("wake standby", 32'(s_standby), 32'd0);
        chk("wake cs", 32'(s_cs), 32'd0);
        step(1, 0, "woken");
        chk("woken pm", 32'(s_pm), 32'd0);
        bus.a_req = 0;
        step(0, 0, "woken drain");

        // Reset between b_gnt and b_rvalid
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 14'h0010;
        @(negedge clk);
        chk("mid b_gnt", 32'(bus.b_gnt), 32'd1);
        rst_n = 1'b0;
        bus.a_req = 1;
        #1;
        chk("mid rst gnts", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd0);
        chk("mid rst ram", {29'd0, ram_cs, ram_wren, ram_standby}, 32'd0);
        @(posedge clk); #1;
        chk("mid rst rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
        rst_n = 1'b1;
        step(1, 0, "post rst A");
        step(0, 1, "post rst B");
        bus.a_req = 0; bus.b_req = 0;
        step(0, 0, "post rst drain");

        // Long idle so the IDLE_CYCLES = 0 instance sees >= 100 cycles
        for (int i = 0; i < 100; i++) step(0, 0, "tail");
        chk("idle0 never sleeps", 32'(bad0), 32'd0);
        chk("idle0 observed cycles", 32'(cyc0 >= 100), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
Shares one 32-bit-wide SPRAM bank between two requesters. The bank is two SB_SPRAM256KA instances, low halfword and high halfword, giving 16K words (64 KiB). Port A is the RV32I instruction fetch (read-only). Port B is the load/store unit (read/write with byte enables). The block does round-robin arbitration, converts byte enables to nibble write masks, and puts the bank into STANDBY after a programmable idle period, waking it on demand.

Parameters:
IDLE_CYCLES, 16, consecutive request-free ACTIVE cycles before entering STANDBY; 0 disables power management.
WAKE_CYCLES, 1, cycles spent in WAKE with standby deasserted before requests are served; legal range 1..15.

Ports:
clk  in  1  system clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
a_req  in  1  fetch request; held until a_gnt.
a_addr  in  14  fetch word address.
a_gnt  out  1  fetch accepted this cycle.
a_rvalid  out  1  a_rdata valid (cycle after a_gnt).
a_rdata  out  32  fetch read data.
b_req  in  1  data request; held, with its fields stable, until b_gnt.
b_we  in  1  1 = write, 0 = read.
b_be  in  4  byte enables (writes only).
b_addr  in  14  data word address.
b_wdata  in  32  write data.
b_gnt  out  1  data request accepted; for a write, the write is complete.
b_rvalid  out  1  b_rdata valid (cycle after a read b_gnt).
b_rdata  out  32  data read data.
ram_addr  out  14  ADDRESS to both SPRAMs.
ram_datain  out  32  [15:0] to low SPRAM, [31:16] to high SPRAM.
ram_maskwren  out  8  [3:0] low MASKWREN, [7:4] high MASKWREN.
ram_wren  out  1  WREN to both.
ram_cs  out  1  CHIPSELECT to both.
ram_standby  out  1  STANDBY to both.
ram_dataout  in  32  {high DATAOUT, low DATAOUT}.
pm_state  out  2  0 = ACTIVE, 1 = STANDBY, 2 = WAKE.

Behaviour:
- Reset (async, rst_n = 0) forces:
  - a_gnt, b_gnt, a_rvalid, b_rvalid, ram_cs, ram_wren, ram_standby = 0; ram_maskwren = 0.
  - state = ACTIVE; idle counter = 0; last_grant = B, so A wins the first tie.
  - ram_addr and ram_datain are don't-care while ram_cs = 0.
- Reset asserted mid-transaction drops any pending rvalid. The requester must reissue.
- Grant decode is combinational from the request inputs, the state and last_grant. gnt and the RAM control outputs assert in the same cycle.
- Arbitration applies only in ACTIVE:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port not equal to last_grant.
  - last_grant updates on every grant.
  - No port is granted twice in a row while the other is requesting.
- Granted cycle drives ram_cs = 1 and ram_addr = the winner's address.
  - Port A, or port B read: ram_wren = 0, ram_maskwren = 0.
  - Port B write: ram_wren = 1, ram_datain = b_wdata, ram_maskwren[2i+1:2i] = {2{b_be[i]}} for i = 0..3.
  - Write with b_be = 0: still granted, ram_wren = 1, no memory bits change.
- Read latency is 1. The x_rvalid register is set the cycle after a read grant and cleared otherwise.
  - a_rdata and b_rdata are combinational copies of ram_dataout; they are meaningful only while the matching rvalid = 1.
  - Writes never raise rvalid. Back-to-back grants give a read result every cycle.
- State machine:
  - ACTIVE: idle counter clears on any request and increments on request-free cycles (saturating). When the counter reaches IDLE_CYCLES (IDLE_CYCLES > 0) → STANDBY: ram_standby = 1, ram_cs = 0.
  - ACTIVE, same cycle as the threshold is reached with a request present: the request is granted and the counter clears; no transition.
  - STANDBY: no grants. Any a_req or b_req → WAKE on the next edge.
  - WAKE: ram_standby = 0, ram_cs = 0, no grants. A counter runs WAKE_CYCLES cycles, then → ACTIVE. Requests held through WAKE are arbitrated normally in the first ACTIVE cycle.
- rvalid pending when STANDBY is entered: impossible, since the threshold is ≥ 1 idle cycle after the last grant.
- Counter widths: idle counter is clog2(IDLE_CYCLES+1) bits, saturating; wake counter is 4 bits.

Test Plan:
- Single read: preload word 0x0123 = 0xDEADBEEF, a_req with a_addr = 0x0123 → a_gnt in the same cycle, a_rvalid = 1 and a_rdata = 0xDEADBEEF the next cycle.
- Byte write: word 0x0010 = 0x00000000, b_we = 1, b_be = 4'b0101, b_wdata = 0xAABBCCDD → ram_maskwren = 8'b00110011; a read-back returns 0x00BB00DD.
- Contention: a_req and b_req held high for 4 cycles after reset → grants in order A, B, A, B; each read's rvalid lands on the correct port one cycle later.
- Power management (IDLE_CYCLES = 16, WAKE_CYCLES = 1): no requests for 16 cycles → pm_state = 1, ram_standby = 1. Then a_req → WAKE for 1 cycle (ram_standby = 0, no gnt), then a_gnt in ACTIVE; data read back is intact.
- Reset mid-read: assert rst_n = 0 in the cycle between b_gnt and b_rvalid → b_rvalid stays 0 and all outputs return to reset values immediately. After release, a tie grants A first.
- IDLE_CYCLES = 0: 100 idle cycles → pm_state stays 0 and ram_standby never asserts.
